// File: rtl/player_mover_pkg.sv
// Shared constants for player_mover: map geometry defines, direction codes, FSM state encoding.
// Geometry defines (CELL_SIZE, MAZE_X0/Y0, MAP_WIDTH/HEIGHT) may be supplied by the parent build.
`ifndef CELL_SIZE
`define CELL_SIZE 16
`endif
`ifndef MAZE_X0
`define MAZE_X0 0
`endif
`ifndef MAZE_Y0
`define MAZE_Y0 0
`endif
`ifndef MAP_WIDTH
`define MAP_WIDTH 11
`endif
`ifndef MAP_HEIGHT
`define MAP_HEIGHT 21
`endif

package player_mover_pkg;

    localparam int unsigned MAZE_W_PX = `MAP_WIDTH * `CELL_SIZE;
    localparam int unsigned MAZE_H_PX = `MAP_HEIGHT * `CELL_SIZE;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_P0     = 3'd1;
    localparam logic [2:0] ST_P1     = 3'd2;
    localparam logic [2:0] ST_P2     = 3'd3;
    localparam logic [2:0] ST_P3     = 3'd4;
    localparam logic [2:0] ST_COMMIT = 3'd5;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
    } pos_t;

    function automatic logic in_range(input logic signed [10:0] v,
                                      input logic signed [10:0] lo,
                                      input logic signed [10:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/player_mover.sv
// Steps the sprite box one STEP per move_tick after probing its four corners through the wall
// checker. Define PLAYER_WRAP_EN to turn the left/right maze bounds into a horizontal tunnel.
module player_mover
    import player_mover_pkg::*;
#(
    parameter int unsigned PLAYER_SIZE = 12,
    parameter int unsigned STEP        = 1,
    parameter int unsigned START_X     = `MAZE_X0 + 18,
    parameter int unsigned START_Y     = `MAZE_Y0 + 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       move_tick,
    input  logic       dir_up,
    input  logic       dir_down,
    input  logic       dir_left,
    input  logic       dir_right,
    output logic [9:0] probe_x,
    output logic [8:0] probe_y,
    input  logic       probe_wall,
    output logic [9:0] pos_x,
    output logic [8:0] pos_y,
    output logic [1:0] facing,
    output logic       busy,
    output logic       moved,
    output logic       bumped
);

    // Bounds are signed so that a step below zero stays negative instead of wrapping.
    localparam logic signed [10:0] MIN_X  = 11'(`MAZE_X0);
    localparam logic signed [10:0] MAX_X  = 11'(`MAZE_X0 + MAZE_W_PX - PLAYER_SIZE);
    localparam logic signed [10:0] MIN_Y  = 11'(`MAZE_Y0);
    localparam logic signed [10:0] MAX_Y  = 11'(`MAZE_Y0 + MAZE_H_PX - PLAYER_SIZE);
    localparam logic signed [10:0] STEP_S = 11'(STEP);
    localparam logic [9:0]         OFF_X  = 10'(PLAYER_SIZE - 1);
    localparam logic [8:0]         OFF_Y  = 9'(PLAYER_SIZE - 1);
    localparam pos_t               START  = '{x: 10'(START_X), y: 9'(START_Y)};

    logic [2:0]         state_q, state_d;
    pos_t               pos_q, pos_d;
    pos_t               cand_q, cand_d;
    logic [1:0]         facing_q, facing_d;
    logic               hit_q, hit_d;
    logic               moved_q, moved_d;
    logic               bumped_q, bumped_d;

    logic               req_any;
    logic [1:0]         req_dir;
    logic signed [10:0] step_x, step_y;
    logic [9:0]         next_x;
    logic               oob;

    always_comb begin
        req_any = dir_up | dir_down | dir_left | dir_right;
        req_dir = DIR_RIGHT;
        step_x  = $signed({1'b0, pos_q.x});
        step_y  = $signed({2'b00, pos_q.y});
        if (dir_up) begin
            req_dir = DIR_UP;
            step_y  = step_y - STEP_S;
        end else if (dir_down) begin
            req_dir = DIR_DOWN;
            step_y  = step_y + STEP_S;
        end else if (dir_left) begin
            req_dir = DIR_LEFT;
            step_x  = step_x - STEP_S;
        end else if (dir_right) begin
            req_dir = DIR_RIGHT;
            step_x  = step_x + STEP_S;
        end
    end

    always_comb begin
        next_x = step_x[9:0];
`ifdef PLAYER_WRAP_EN
        if (step_x < MIN_X) begin
            next_x = MAX_X[9:0];
        end else if (step_x > MAX_X) begin
            next_x = MIN_X[9:0];
        end
        oob = !in_range(step_y, MIN_Y, MAX_Y);
`else
        oob = !in_range(step_x, MIN_X, MAX_X) || !in_range(step_y, MIN_Y, MAX_Y);
`endif
    end

    // Corner mux; IDLE and COMMIT present the top-left corner.
    always_comb begin
        probe_x = cand_q.x;
        probe_y = cand_q.y;
        case (state_q)
            ST_P1: probe_x = cand_q.x + OFF_X;
            ST_P2: probe_y = cand_q.y + OFF_Y;
            ST_P3: begin
                probe_x = cand_q.x + OFF_X;
                probe_y = cand_q.y + OFF_Y;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        cand_d   = cand_q;
        facing_d = facing_q;
        hit_d    = hit_q;
        moved_d  = 1'b0;
        bumped_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (move_tick && req_any) begin
                    facing_d = req_dir;
                    cand_d   = '{x: next_x, y: step_y[8:0]};
                    hit_d    = oob;
                    state_d  = oob ? ST_COMMIT : ST_P0;
                end
            end
            ST_P0: begin
                hit_d   = hit_q | probe_wall;
                state_d = ST_P1;
            end
            ST_P1: begin
                hit_d   = hit_q | probe_wall;
                state_d = ST_P2;
            end
            ST_P2: begin
                hit_d   = hit_q | probe_wall;
                state_d = ST_P3;
            end
            ST_P3: begin
                hit_d   = hit_q | probe_wall;
                state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                if (hit_q) begin
                    bumped_d = 1'b1;
                end else begin
                    pos_d   = cand_q;
                    moved_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pos_q    <= START;
            cand_q   <= START;
            facing_q <= DIR_UP;
            hit_q    <= 1'b0;
            moved_q  <= 1'b0;
            bumped_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            cand_q   <= cand_d;
            facing_q <= facing_d;
            hit_q    <= hit_d;
            moved_q  <= moved_d;
            bumped_q <= bumped_d;
        end
    end

    assign pos_x  = pos_q.x;
    assign pos_y  = pos_q.y;
    assign facing = facing_q;
    assign busy   = (state_q != ST_IDLE);
    assign moved  = moved_q;
    assign bumped = bumped_q;

endmodule

// File: tb/tb_player_mover.sv
// Bench for player_mover: directed vector table, hand-written reset/drop sequences and random
// moves over random maps, all checked against a tile-grid reference model.
module tb_player_mover;

    localparam int MAP_W = 11;
    localparam int MAP_H = 21;
    localparam int CELL  = 16;
    localparam int S     = 12;
    localparam int STEP  = 1;
    localparam int XMAX  = MAP_W * CELL - S;
    localparam int YMAX  = MAP_H * CELL - S;

    logic       clk = 1'b0;
    logic       rst;
    logic       move_tick;
    logic       dir_up, dir_down, dir_left, dir_right;
    logic [9:0] probe_x;
    logic [8:0] probe_y;
    logic       probe_wall;
    logic [9:0] pos_x;
    logic [8:0] pos_y;
    logic [1:0] facing;
    logic       busy, moved, bumped;

    bit wall_map [MAP_H][MAP_W];
    int n_checks = 0;
    int n_fail   = 0;
    int m_x, m_y, m_f;

    typedef struct {
        logic [3:0] dirs;   // {up, down, left, right}
        int         reps;
        int         exp_x;
        int         exp_y;
        int         exp_f;
        int         exp_moved;
        int         exp_bumped;
    } vec_t;

    vec_t vecs[$];

    player_mover #(
        .PLAYER_SIZE(12),
        .STEP       (1),
        .START_X    (18),
        .START_Y    (18)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .move_tick (move_tick),
        .dir_up    (dir_up),
        .dir_down  (dir_down),
        .dir_left  (dir_left),
        .dir_right (dir_right),
        .probe_x   (probe_x),
        .probe_y   (probe_y),
        .probe_wall(probe_wall),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .facing    (facing),
        .busy      (busy),
        .moved     (moved),
        .bumped    (bumped)
    );

    always #5 clk = ~clk;

    function automatic bit wall_at(input int x, input int y);
        if (x < 0 || y < 0 || x >= MAP_W * CELL || y >= MAP_H * CELL) return 1'b1;
        return wall_map[y / CELL][x / CELL];
    endfunction

    always_comb probe_wall = wall_at(int'(probe_x), int'(probe_y));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_move(input logic [3:0] d, input int x, input int y, input int f,
                              output int nx, output int ny, output int nf,
                              output bit act, output bit oob, output bit blk,
                              output int cx, output int cy);
        int dx, dy;
        dx = 0; dy = 0;
        act = (d != 4'b0000);
        nx = x; ny = y; nf = f; cx = x; cy = y; oob = 1'b0; blk = 1'b0;
        if (!act) return;
        if (d[3]) begin nf = 0; dy = -STEP; end
        else if (d[2]) begin nf = 1; dy = STEP; end
        else if (d[1]) begin nf = 2; dx = -STEP; end
        else begin nf = 3; dx = STEP; end
        cx = x + dx;
        cy = y + dy;
`ifdef PLAYER_WRAP_EN
        if (cx < 0) cx = XMAX;
        else if (cx > XMAX) cx = 0;
`endif
        oob = (cx < 0) || (cx > XMAX) || (cy < 0) || (cy > YMAX);
        blk = oob || wall_at(cx, cy) || wall_at(cx + S - 1, cy) ||
              wall_at(cx, cy + S - 1) || wall_at(cx + S - 1, cy + S - 1);
        if (!blk) begin
            nx = cx;
            ny = cy;
        end
    endtask

    // One tick with direction d; samples outputs #1 after edges T..T+7.
    task automatic do_move(input logic [3:0] d, output bit saw_mv, output bit saw_bp);
        int ex, ey, ef, cx, cy, exp_n, busy_n, mv_n, bp_n, mv_at, bp_at;
        bit act, oob, blk;
        int pr [4];
        int ecx [4];
        int ecy [4];
        model_move(d, m_x, m_y, m_f, ex, ey, ef, act, oob, blk, cx, cy);
        @(negedge clk);
        {dir_up, dir_down, dir_left, dir_right} = d;
        move_tick = 1'b1;
        @(posedge clk);
        #1;
        move_tick = 1'b0;
        busy_n = 0; mv_n = 0; bp_n = 0; mv_at = -1; bp_at = -1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (busy) busy_n++;
            if (moved) begin mv_n++; mv_at = k; end
            if (bumped) begin bp_n++; bp_at = k; end
            if (k < 4) pr[k] = int'(probe_x) * 1024 + int'(probe_y);
        end
        {dir_up, dir_down, dir_left, dir_right} = 4'b0000;
        exp_n = !act ? 0 : (oob ? 1 : 5);
        check("busy_cycles", busy_n, exp_n);
        check("moved_pulses", mv_n, (act && !blk) ? 1 : 0);
        check("bumped_pulses", bp_n, (act && blk) ? 1 : 0);
        if (act) check("pulse_cycle", blk ? bp_at : mv_at, exp_n);
        if (act && !oob) begin
            ecx = '{cx, cx + S - 1, cx, cx + S - 1};
            ecy = '{cy, cy, cy + S - 1, cy + S - 1};
            for (int k = 0; k < 4; k++) check("probe_corner", pr[k], ecx[k] * 1024 + ecy[k]);
        end
        check("pos_x", 32'(pos_x), ex);
        check("pos_y", 32'(pos_y), ey);
        check("facing", 32'(facing), ef);
        m_x = ex; m_y = ey; m_f = ef;
        saw_mv = (mv_n > 0);
        saw_bp = (bp_n > 0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_x = 18; m_y = 18; m_f = 0;
    endtask

    initial begin
        bit mv, bp;
        int xw, xr, busy_n, mv_n, bp_n, quiet;
        rst = 1'b1;
        move_tick = 1'b0;
        {dir_up, dir_down, dir_left, dir_right} = 4'b0000;
        for (int r = 0; r < MAP_H; r++)
            for (int c = 0; c < MAP_W; c++) wall_map[r][c] = (c == 2);

        // Reset state, observed while rst is still held.
        #12;
        check("rst_pos_x", 32'(pos_x), 18);
        check("rst_pos_y", 32'(pos_y), 18);
        check("rst_facing", 32'(facing), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_pulses", 32'({moved, bumped}), 0);
        check("rst_probe", int'(probe_x) * 1024 + int'(probe_y), 18 * 1024 + 18);
        @(negedge clk);
        rst = 1'b0;
        m_x = 18; m_y = 18; m_f = 0;

`ifdef PLAYER_WRAP_EN
        xw = 164; xr = 0;
`else
        xw = 0; xr = 1;
`endif
        vecs.push_back('{4'b0001, 1, 19, 18, 3, 1, 0});   // open floor
        vecs.push_back('{4'b0001, 1, 20, 18, 3, 1, 0});
        vecs.push_back('{4'b0001, 1, 20, 18, 3, 0, 1});   // wall column at x 32..47
        vecs.push_back('{4'b1010, 1, 20, 17, 0, 1, 0});   // up beats left
        vecs.push_back('{4'b0010, 20, 0, 17, 2, 1, 0});
`ifdef PLAYER_WRAP_EN
        vecs.push_back('{4'b0010, 1, 164, 17, 2, 1, 0});  // tunnel to max x
`else
        vecs.push_back('{4'b0010, 1, 0, 17, 2, 0, 1});    // left bound
`endif
        vecs.push_back('{4'b0100, 1, xw, 18, 1, 1, 0});
        vecs.push_back('{4'b0000, 1, xw, 18, 1, 0, 0});   // no direction: ignored
        vecs.push_back('{4'b1000, 18, xw, 0, 0, 1, 0});
        vecs.push_back('{4'b1000, 1, xw, 0, 0, 0, 1});    // top bound
        vecs.push_back('{4'b0101, 1, xw, 1, 1, 1, 0});    // down beats right
        vecs.push_back('{4'b0001, 1, xr, 1, 3, 1, 0});

        for (int i = 0; i < vecs.size(); i++) begin
            mv = 1'b0; bp = 1'b0;
            for (int r = 0; r < vecs[i].reps; r++) do_move(vecs[i].dirs, mv, bp);
            check("tbl_pos_x", 32'(pos_x), vecs[i].exp_x);
            check("tbl_pos_y", 32'(pos_y), vecs[i].exp_y);
            check("tbl_facing", 32'(facing), vecs[i].exp_f);
            check("tbl_moved", mv ? 1 : 0, vecs[i].exp_moved);
            check("tbl_bumped", bp ? 1 : 0, vecs[i].exp_bumped);
        end

        // Second tick and direction change while busy are dropped.
        begin
            int ex, ey, ef, cx, cy;
            bit act, oob, blk;
            model_move(4'b1010, m_x, m_y, m_f, ex, ey, ef, act, oob, blk, cx, cy);
            @(negedge clk);
            {dir_up, dir_down, dir_left, dir_right} = 4'b1010;
            move_tick = 1'b1;
            @(posedge clk);
            #1;
            move_tick = 1'b0;
            busy_n = 0; mv_n = 0; bp_n = 0;
            for (int k = 0; k < 10; k++) begin
                if (k > 0) begin
                    @(posedge clk);
                    #1;
                end
                if (busy) busy_n++;
                if (moved) mv_n++;
                if (bumped) bp_n++;
                if (k == 1) begin
                    move_tick = 1'b1;
                    {dir_up, dir_down, dir_left, dir_right} = 4'b0001;
                end else begin
                    move_tick = 1'b0;
                end
            end
            {dir_up, dir_down, dir_left, dir_right} = 4'b0000;
            check("drop_busy_cycles", busy_n, 5);
            check("drop_moved_pulses", mv_n, 1);
            check("drop_bumped_pulses", bp_n, 0);
            check("drop_pos_x", 32'(pos_x), ex);
            check("drop_pos_y", 32'(pos_y), ey);
            check("drop_facing", 32'(facing), 0);
            m_x = ex; m_y = ey; m_f = ef;
        end

        // Reset asserted during P2.
        @(negedge clk);
        dir_right = 1'b1;
        move_tick = 1'b1;
        @(posedge clk);
        #1;
        move_tick = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("busy_before_rst", 32'(busy), 1);
        rst = 1'b1;
        #1;
        check("midrst_pos_x", 32'(pos_x), 18);
        check("midrst_pos_y", 32'(pos_y), 18);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_facing", 32'(facing), 0);
        check("midrst_pulses", 32'({moved, bumped}), 0);
        @(negedge clk);
        rst = 1'b0;
        dir_right = 1'b0;
        quiet = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (moved || bumped || busy) quiet++;
        end
        check("post_rst_quiet", quiet, 0);
        m_x = 18; m_y = 18; m_f = 0;
        do_move(4'b0001, mv, bp);

        // Random moves over random maps.
        apply_reset();
        for (int n = 0; n < 240; n++) begin
            if (n % 60 == 0) begin
                for (int r = 0; r < MAP_H; r++)
                    for (int c = 0; c < MAP_W; c++)
                        wall_map[r][c] = ($urandom_range(0, 7) == 0);
            end
            do_move(4'($urandom_range(0, 15)), mv, bp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
